conv_window_fetch: RTL and testbench

Downstream of the input-feature SRAM: scans a 56×56 input map for a 3×3, stride-1, pad-1 convolution and emits the 9 tap words of every output position in order. It drives the SRAM read address, absorbs the SRAM's one-cycle registered read latency, and inserts zero words for padded taps without reading the SRAM. Output is a valid/ready stream to the convolution datapath.

---
 rtl/conv_window_fetch.sv | 188 ++++++++++++++++++
 tb/tb_conv_window_fetch.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_fetch.sv
// 3x3 / stride-1 / pad-1 window scanner over a square feature map held in a registered-read SRAM.
// Emits the 9 tap words of every output position, with zero words for padded taps.
module conv_window_fetch #(
    parameter int DATA_W = 129,
    parameter int IMG_W  = 56,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_tap,
    output logic [5:0]        out_row,
    output logic [5:0]        out_col,
    output logic              out_last
);
    localparam int TAG_W = 4 + 6 + 6 + 1;
    localparam logic signed [6:0] IMG_S   = 7'(IMG_W);
    localparam logic [5:0]        LAST_RC = 6'(IMG_W - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state_reg, state_next;

    logic [5:0]        row_reg, col_reg;
    logic [1:0]        ky_reg, kx_reg;
    logic [ADDR_W-1:0] addr_reg;

    logic              inflight_reg, s1_zero_reg, s1_last_reg;
    logic [3:0]        s1_tap_reg;
    logic [5:0]        s1_row_reg, s1_col_reg;

    logic              wr_ptr_reg, rd_ptr_reg;
    logic [1:0]        count_reg;
    logic              done_reg;

    logic [1:0][DATA_W-1:0] fifo_data;
    logic [1:0][TAG_W-1:0]  fifo_tag;

    logic              pop, push, issue, tap_last, scan_last, drained, done_set;
    logic signed [6:0] ir, ic;
    logic              in_bounds;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        credit_used;

    // Input coordinate of the tap being considered this cycle.
    assign ir        = $signed({1'b0, row_reg}) + $signed({5'b0, ky_reg}) - 7'sd1;
    assign ic        = $signed({1'b0, col_reg}) + $signed({5'b0, kx_reg}) - 7'sd1;
    assign in_bounds = !ir[6] && (ir < IMG_S) && !ic[6] && (ic < IMG_S);
    assign rd_addr   = ADDR_W'(ir[5:0]) * ADDR_W'(IMG_W) + ADDR_W'(ic[5:0]);

    assign tap_last  = (ky_reg == 2'd2) && (kx_reg == 2'd2);
    assign scan_last = tap_last && (row_reg == LAST_RC) && (col_reg == LAST_RC);

    assign out_valid = (count_reg != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = inflight_reg;

    // Every in-flight tap owns a FIFO slot, so issue only while a slot is guaranteed free.
    assign credit_used = {1'b0, count_reg} + {2'b0, inflight_reg};
    assign issue       = (state_reg == FETCH) && (credit_used < (3'd2 + {2'b0, pop}));
    assign drained     = !inflight_reg && ((count_reg == 2'd0) || ((count_reg == 2'd1) && pop));

    assign sram_addr = (issue && in_bounds) ? rd_addr : addr_reg;
    assign done      = done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   if (issue && scan_last) state_next = DRAIN;
            DRAIN:   if (drained) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_reg != IDLE);
        done_set = (state_reg == DRAIN) && drained;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_reg  <= '0;
            col_reg  <= '0;
            ky_reg   <= '0;
            kx_reg   <= '0;
            addr_reg <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= done_set;
            if (state_reg == IDLE && start) begin
                row_reg <= '0;
                col_reg <= '0;
                ky_reg  <= '0;
                kx_reg  <= '0;
            end else if (issue) begin
                if (in_bounds) addr_reg <= rd_addr;
                if (kx_reg != 2'd2) begin
                    kx_reg <= kx_reg + 2'd1;
                end else begin
                    kx_reg <= '0;
                    if (ky_reg != 2'd2) begin
                        ky_reg <= ky_reg + 2'd1;
                    end else begin
                        ky_reg <= '0;
                        if (col_reg != LAST_RC) begin
                            col_reg <= col_reg + 6'd1;
                        end else begin
                            col_reg <= '0;
                            row_reg <= (row_reg == LAST_RC) ? 6'd0 : row_reg + 6'd1;
                        end
                    end
                end
            end
        end
    end

    // Stage 1: tag travels alongside the SRAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg <= 1'b0;
            s1_zero_reg  <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_tap_reg   <= '0;
            s1_row_reg   <= '0;
            s1_col_reg   <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                s1_zero_reg <= !in_bounds;
                s1_last_reg <= scan_last;
                s1_tap_reg  <= 4'(ky_reg) * 4'd3 + 4'(kx_reg);
                s1_row_reg  <= row_reg;
                s1_col_reg  <= col_reg;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [DATA_W-1:0] data_reg;
        logic [TAG_W-1:0]  tag_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                data_reg <= '0;
                tag_reg  <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                data_reg <= s1_zero_reg ? '0 : sram_dout;
                tag_reg  <= {s1_tap_reg, s1_row_reg, s1_col_reg, s1_last_reg};
            end
        end
        assign fifo_data[gi] = data_reg;
        assign fifo_tag[gi]  = tag_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= !wr_ptr_reg;
            if (pop)  rd_ptr_reg <= !rd_ptr_reg;
            unique case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: ;
            endcase
        end
    end

    assign out_data = fifo_data[rd_ptr_reg];
    assign {out_tap, out_row, out_col, out_last} = fifo_tag[rd_ptr_reg];

endmodule

// File: tb/tb_conv_window_fetch.sv
// Bench for conv_window_fetch: SRAM model, window-order reference model and per-handshake checker.
module tb_conv_window_fetch;
    localparam int DATA_W    = 129;
    localparam int IMG_W     = 56;
    localparam int ADDR_W    = 12;
    localparam int TOTAL     = IMG_W * IMG_W * 9;
    localparam int STALL_IDX = (10 * IMG_W + 10) * 9 + 3;
    localparam int RESET_IDX = (30 * IMG_W + 5) * 9;

    typedef logic [DATA_W-1:0] word_t;

    logic              clk = 1'b0;
    logic              rst, start, busy, done;
    logic [ADDR_W-1:0] sram_addr;
    word_t             sram_dout, out_data;
    logic              out_valid, out_ready, out_last;
    logic [3:0]        out_tap;
    logic [5:0]        out_row, out_col;

    word_t mem [IMG_W*IMG_W];
    int    cyc = 0;
    int    n_tests = 0, n_fail = 0;

    // Monitor state (written only by the monitor, except resets done between scans).
    bit          mon_en = 1'b0;
    int          hs_idx, zero_cnt, last_cnt, done_cnt;
    int          first_valid_edge, last_hs_edge, done_edge, start_edge;
    word_t       cap_data [9];
    int          cap_edge [9];
    word_t       cap_corner;
    bit          held_valid;
    word_t       held_data;
    logic [16:0] held_tag;

    int lit_val [9] = '{0, 0, 0, 0, 0, 1, 0, 56, 57};
    bit lit_pad [9] = '{1, 1, 1, 1, 0, 0, 1, 0, 0};

    conv_window_fetch #(.DATA_W(DATA_W), .IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .sram_addr(sram_addr), .sram_dout(sram_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tap(out_tap), .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) sram_dout <= (int'(sram_addr) < IMG_W*IMG_W) ? mem[sram_addr] : '0;

    function automatic word_t mem_word(int a);
        logic [63:0] lo;
        lo = 64'(a);
        return {1'b1, lo ^ 64'hDEAD_BEEF_CAFE_F00D, lo};
    endfunction

    // Word i of the scan: position i/9 in row-major order, tap i%9.
    function automatic word_t ref_data(int i);
        int pos, t, ir, ic;
        pos = i / 9;
        t   = i % 9;
        ir  = pos / IMG_W + t / 3 - 1;
        ic  = pos % IMG_W + t % 3 - 1;
        if (ir < 0 || ir >= IMG_W || ic < 0 || ic >= IMG_W) return '0;
        return mem_word(ir * IMG_W + ic);
    endfunction

    function automatic logic [16:0] ref_tag(int i);
        return {4'(i % 9), 6'((i / 9) / IMG_W), 6'((i / 9) % IMG_W), (i == TOTAL - 1)};
    endfunction

    task automatic chk(input string nm, input word_t act, input word_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Compare process: every handshake against the model, stalled outputs held stable.
    initial begin
        logic [16:0] cur_tag;
        forever begin
            @(negedge clk);
            cur_tag = {out_tap, out_row, out_col, out_last};
            if (mon_en) begin
                if (held_valid) begin
                    chk("stall_valid", word_t'(out_valid), word_t'(1));
                    chk("stall_data", out_data, held_data);
                    chk("stall_tag", word_t'(cur_tag), word_t'(held_tag));
                end
                held_valid = out_valid && !out_ready;
                held_data  = out_data;
                held_tag   = cur_tag;
                if (out_valid && first_valid_edge < 0) first_valid_edge = cyc;
                if (out_valid && out_ready) begin
                    if (hs_idx >= TOTAL) begin
                        chk("extra_word", word_t'(hs_idx), word_t'(TOTAL - 1));
                    end else begin
                        chk("hs_data", out_data, ref_data(hs_idx));
                        chk("hs_tag", word_t'(cur_tag), word_t'(ref_tag(hs_idx)));
                    end
                    if (hs_idx < 9) begin
                        cap_data[hs_idx] = out_data;
                        cap_edge[hs_idx] = cyc + 1;
                    end
                    if (hs_idx == TOTAL - 9) cap_corner = out_data;
                    if (out_data == '0) zero_cnt++;
                    if (out_last) last_cnt++;
                    last_hs_edge = cyc + 1;
                    hs_idx++;
                end
                if (done) begin
                    done_cnt++;
                    done_edge = cyc;
                end
            end
        end
    end

    task automatic begin_scan();
        hs_idx = 0; zero_cnt = 0; last_cnt = 0; done_cnt = 0;
        first_valid_edge = -1; last_hs_edge = -1; done_edge = -1;
        held_valid = 1'b0;
        @(posedge clk); #1;
        start      = 1'b1;
        start_edge = cyc + 1;
        mon_en     = 1'b1;
    endtask

    task automatic check_first_taps();
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("tap%0d_value", i), word_t'(cap_data[i][63:0]), word_t'(lit_val[i]));
            chk($sformatf("tap%0d_real", i), word_t'(cap_data[i][128]), word_t'(!lit_pad[i]));
        end
    endtask

    // mode 0: out_ready held high; mode 1: random out_ready plus stall and stray start.
    task automatic run_full_scan(input int mode, input int budget);
        int               n = 0;
        int               stall_left = 20;
        bit               pulsed = 1'b0;
        logic [ADDR_W-1:0] stall_addr = '0;
        begin_scan();
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
            start     = 1'b0;
            out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 1 && hs_idx == STALL_IDX && stall_left > 0) begin
                out_ready = 1'b0;
                if (stall_left == 17) stall_addr = sram_addr;
                if (stall_left < 17) chk("stall_addr_hold", word_t'(sram_addr), word_t'(stall_addr));
                if (stall_left == 1) begin
                    chk("resume_valid", word_t'(out_valid), word_t'(1));
                    chk("resume_tap", word_t'(out_tap), word_t'(3));
                    chk("resume_pos", word_t'({out_row, out_col}), word_t'({6'd10, 6'd10}));
                    chk("resume_value", word_t'(out_data[63:0]), word_t'(569));
                end
                stall_left--;
            end
            if (mode == 1 && !pulsed && hs_idx >= 1000) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
        end
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("scan_words", word_t'(hs_idx), word_t'(TOTAL));
        chk("scan_zero_words", word_t'(zero_cnt), word_t'(668));
        chk("scan_last_count", word_t'(last_cnt), word_t'(1));
        chk("scan_done_count", word_t'(done_cnt), word_t'(1));
        chk("done_after_last", word_t'(done_edge), word_t'(last_hs_edge));
        chk("corner_tap0_addr", word_t'(cap_corner[63:0]), word_t'(3078));
        chk("busy_after_scan", word_t'(busy), word_t'(0));
        check_first_taps();
        if (mode == 0) begin
            chk("first_valid_edge", word_t'(first_valid_edge - start_edge), word_t'(2));
            for (int i = 1; i < 9; i++)
                chk($sformatf("tap%0d_back_to_back", i), word_t'(cap_edge[i] - cap_edge[0]), word_t'(i));
            chk("scan_time", word_t'(last_hs_edge - start_edge), word_t'(TOTAL + 2));
        end
        if (mode == 1) chk("stall_completed", word_t'(stall_left), word_t'(0));
        $display("[TB] scan mode %0d: %0d words, %0d zero words, %0d done pulses, %0d cycles",
                 mode, hs_idx, zero_cnt, done_cnt, last_hs_edge - start_edge);
    endtask

    initial begin
        int n;
        for (int a = 0; a < IMG_W * IMG_W; a++) mem[a] = mem_word(a);
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", word_t'(busy), word_t'(0));
        chk("rst_done", word_t'(done), word_t'(0));
        chk("rst_valid", word_t'(out_valid), word_t'(0));
        chk("rst_addr", word_t'(sram_addr), word_t'(0));
        chk("rst_data", out_data, word_t'(0));
        chk("rst_tag", word_t'({out_tap, out_row, out_col, out_last}), word_t'(0));
        $display("[TB] reset state sampled");
        @(posedge clk); #1;
        rst = 1'b0;

        run_full_scan(0, 40000);
        run_full_scan(1, 70000);

        // Mid-scan reset when position (30,5) tap 0 is at the output.
        begin_scan();
        n = 0;
        while (hs_idx < RESET_IDX && n < 20000) begin
            @(posedge clk); #1;
            n++;
            start     = 1'b0;
            out_ready = 1'b1;
        end
        chk("pre_reset_reached", word_t'(hs_idx), word_t'(RESET_IDX));
        chk("pre_reset_pos", word_t'({out_tap, out_row, out_col}), word_t'({4'd0, 6'd30, 6'd5}));
        mon_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_reset_valid", word_t'(out_valid), word_t'(0));
        chk("post_reset_busy", word_t'(busy), word_t'(0));
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("post_reset_no_done", word_t'(n), word_t'(0));
        $display("[TB] reset at output position (30,5) after %0d words", hs_idx);

        begin_scan();
        repeat (30) begin
            @(posedge clk); #1;
            start     = 1'b0;
            out_ready = 1'b1;
        end
        mon_en = 1'b0;
        chk("restart_first_valid", word_t'(first_valid_edge - start_edge), word_t'(2));
        chk("restart_progress", word_t'(hs_idx >= 9), word_t'(1));
        check_first_taps();
        $display("[TB] restart after reset: %0d words", hs_idx);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
